// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO decoupling instruction fetch from decode.
// Holds {PC, instruction, redirect flag} in program order. On a flush it
// empties itself and then ignores the one stale fetch response that is still
// in flight from the 1-cycle instruction memory.
module fetch_queue #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            globalReset,
    input  logic            fetchValid,
    input  logic [WIDTH:0]  fetchPC,
    input  logic [WIDTH:0]  fetchInstr,
    input  logic            fetchRedirect,
    input  logic            flush,
    input  logic            decodeReady,
    output logic            decodeValid,
    output logic [WIDTH:0]  decodePC,
    output logic [WIDTH:0]  decodeInstr,
    output logic            decodeRedirect,
    output logic            full,
    output logic [PTRW:0]   count
);

    typedef struct packed {
        logic [WIDTH:0] pc;
        logic [WIDTH:0] instr;
        logic           redirect;
    } entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    entry_t          mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    state_t          state;
    state_t          state_next;
    logic            push;
    logic            pop;
    entry_t          head;

    // full comes from the registered count, so a pop in the same cycle does
    // not open a slot for the refused fetch; fetch stays frozen and retries.
    assign full        = (count == (PTRW+1)'(DEPTH));
    assign decodeValid = (count != '0);
    assign push        = fetchValid && !full && (state == RUN) && !flush;
    assign pop         = decodeValid && decodeReady && !flush;

    // Head read is combinational; outputs are forced to zero when empty so
    // stale storage never leaks out.
    always_comb begin
        head           = mem[rd_ptr];
        decodePC       = '0;
        decodeInstr    = '0;
        decodeRedirect = 1'b0;
        if (decodeValid) begin
            decodePC       = head.pc;
            decodeInstr    = head.instr;
            decodeRedirect = head.redirect;
        end
    end

    // Entry storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: fetchPC, instr: fetchInstr, redirect: fetchRedirect};
        end
    end

    // Pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) state <= RUN;
        else             state <= state_next;
    end

    // Next state: any flush (re)enters DROP; DROP lasts one cycle otherwise.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = DROP;
            DROP:    state_next = flush ? DROP : RUN;
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed check of fetch_queue (DEPTH=4),
// plus hand-written sequences for asynchronous reset mid-cycle.
module tb_fetch_queue;

    localparam int WIDTH = 31;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic            clk;
    logic            globalReset;
    logic            fetchValid;
    logic [WIDTH:0]  fetchPC;
    logic [WIDTH:0]  fetchInstr;
    logic            fetchRedirect;
    logic            flush;
    logic            decodeReady;
    logic            decodeValid;
    logic [WIDTH:0]  decodePC;
    logic [WIDTH:0]  decodeInstr;
    logic            decodeRedirect;
    logic            full;
    logic [PTRW:0]   count;

    int checks;
    int fails;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk           (clk),
        .globalReset   (globalReset),
        .fetchValid    (fetchValid),
        .fetchPC       (fetchPC),
        .fetchInstr    (fetchInstr),
        .fetchRedirect (fetchRedirect),
        .flush         (flush),
        .decodeReady   (decodeReady),
        .decodeValid   (decodeValid),
        .decodePC      (decodePC),
        .decodeInstr   (decodeInstr),
        .decodeRedirect(decodeRedirect),
        .full          (full),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs for a cycle, and expected outputs after its edge.
    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        efull;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fv, input logic [31:0] pc, input logic fl,
                       input logic rdy, input logic ev, input logic [31:0] epc,
                       input logic efull, input logic [2:0] ecnt);
        vecs.push_back('{fv: fv, pc: pc, fl: fl, rdy: rdy, ev: ev, epc: epc,
                         efull: efull, ecnt: ecnt});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction and redirect are derived from the PC so one field drives all three.
    task automatic drive(input logic fv, input logic [31:0] pc, input logic fl, input logic rdy);
        fetchValid    = fv;
        fetchPC       = pc;
        fetchInstr    = pc + 32'h90;
        fetchRedirect = pc[0];
        flush         = fl;
        decodeReady   = rdy;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                              input logic efull, input logic [2:0] ecnt);
        check({tag, ".valid"}, 64'(decodeValid), 64'(ev));
        check({tag, ".count"}, 64'(count), 64'(ecnt));
        check({tag, ".full"}, 64'(full), 64'(efull));
        check({tag, ".pc"}, 64'(decodePC), ev ? 64'(epc) : 64'h0);
        check({tag, ".instr"}, 64'(decodeInstr), ev ? 64'(epc + 32'h90) : 64'h0);
        check({tag, ".redir"}, 64'(decodeRedirect), ev ? 64'(epc[0]) : 64'h0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;

        // Test 1: three pushes with decode stalled.
        add(1, 32'h10, 0, 0, 1, 32'h10, 0, 1);
        add(1, 32'h11, 0, 0, 1, 32'h10, 0, 2);
        add(1, 32'h12, 0, 0, 1, 32'h10, 0, 3);
        // Test 2: fill, refuse 0x14, then pop while 0x14 is re-presented (still refused).
        add(1, 32'h13, 0, 0, 1, 32'h10, 1, 4);
        add(1, 32'h14, 0, 0, 1, 32'h10, 1, 4);
        add(1, 32'h14, 0, 1, 1, 32'h11, 0, 3);
        // Drain, then decodeReady while empty does nothing.
        add(0, 32'h0,  0, 1, 1, 32'h12, 0, 2);
        add(0, 32'h0,  0, 1, 1, 32'h13, 0, 1);
        add(0, 32'h0,  0, 1, 0, 32'h0,  0, 0);
        add(0, 32'h0,  0, 1, 0, 32'h0,  0, 0);
        // Test 3: steady stream, occupancy held at 1, pointers wrap.
        for (int k = 0; k < 10; k++)
            add(1, 32'h20 + 32'(k), 0, 1, 1, 32'h20 + 32'(k), 0, 1);
        // Build to 3 entries.
        add(1, 32'h2A, 0, 0, 1, 32'h29, 0, 2);
        add(1, 32'h2B, 0, 0, 1, 32'h29, 0, 3);
        // Test 4: flush with a concurrent fetch; next fetch dropped; then accepted.
        add(1, 32'h30, 1, 0, 0, 32'h0,  0, 0);
        add(1, 32'h31, 0, 0, 0, 32'h0,  0, 0);
        add(1, 32'h40, 0, 0, 1, 32'h40, 0, 1);
        // Test 5: back-to-back flush (first one also carries a pop request).
        add(1, 32'h50, 1, 1, 0, 32'h0,  0, 0);
        add(1, 32'h51, 1, 0, 0, 32'h0,  0, 0);
        add(1, 32'h52, 0, 0, 0, 32'h0,  0, 0);
        add(1, 32'h53, 0, 0, 1, 32'h53, 0, 1);
        add(1, 32'h60, 0, 0, 1, 32'h53, 0, 2);

        // Reset state, with a fetch presented during reset.
        drive(1, 32'h99, 0, 0);
        globalReset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out("reset", 0, 32'h0, 0, 0);
        globalReset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].fl, vecs[i].rdy);
            @(posedge clk);
            #1;
            expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc,
                       vecs[i].efull, vecs[i].ecnt);
        end

        // Test 6a: async reset mid-cycle with count=2 in RUN.
        drive(0, 32'h0, 0, 0);
        #3 globalReset = 1'b1;
        #1;
        expect_out("arst_run", 0, 32'h0, 0, 0);
        #1 globalReset = 1'b0;

        // Test 6b: enter DROP via flush, then async reset mid-cycle.
        drive(1, 32'h61, 0, 0);
        @(posedge clk);
        #1;
        expect_out("pre_drop", 1, 32'h61, 0, 1);
        drive(1, 32'h62, 0, 0);
        @(posedge clk);
        #1;
        expect_out("pre_drop2", 1, 32'h61, 0, 2);
        drive(0, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        expect_out("flush_drop", 0, 32'h0, 0, 0);
        drive(0, 32'h0, 0, 0);
        #3 globalReset = 1'b1;
        #1;
        expect_out("arst_drop", 0, 32'h0, 0, 0);
        #1 globalReset = 1'b0;
        // Reset returned the FSM to RUN, so this fetch must be stored.
        drive(1, 32'h70, 0, 0);
        @(posedge clk);
        #1;
        expect_out("post_rst", 1, 32'h70, 0, 1);
        drive(0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
